// File: rtl/serial_subtractor.sv
// Multi-cycle N-bit subtractor: one W-bit slice per cycle, LSB chunk first,
// with the borrow carried between chunks in a register. Valid/ready on both sides.
module serial_subtractor #(
    parameter int N = 64,
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] inp1,
    input  logic [N-1:0] inp2,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] diff,
    output logic         bout,
    output logic         ovf
);
    localparam int NCHUNK = N / W;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {IDLE, SUB, DONE} state_t;

    state_t          state_q, state_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic            borrow_q, borrow_d;
    logic [N-1:0]    a_q, a_d;
    logic [N-1:0]    b_q, b_d;
    logic [N-1:0]    diff_q, diff_d;
    logic            bout_q, bout_d;
    logic            ovf_q, ovf_d;
    logic            out_valid_q, out_valid_d;

    logic [W-1:0]    a_chunks [NCHUNK];
    logic [W-1:0]    b_chunks [NCHUNK];
    logic [W-1:0]    a_chunk, b_chunk, slice_d;
    logic [W:0]      slice_res;
    logic            slice_b;
    logic            last_chunk;

    // Extra top bit of the W+1-bit difference is the borrow out of this slice.
    assign a_chunk    = a_chunks[idx_q];
    assign b_chunk    = b_chunks[idx_q];
    assign slice_res  = {1'b0, a_chunk} - {1'b0, b_chunk} - {{W{1'b0}}, borrow_q};
    assign slice_d    = slice_res[W-1:0];
    assign slice_b    = slice_res[W];
    assign last_chunk = (idx_q == IDXW'(NCHUNK - 1));

    generate
        for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_chunk
            assign a_chunks[gi] = a_q[gi*W +: W];
            assign b_chunks[gi] = b_q[gi*W +: W];
            assign diff_d[gi*W +: W] = (state_q == SUB && idx_q == IDXW'(gi))
                                       ? slice_d : diff_q[gi*W +: W];
        end
    endgenerate

    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = out_valid_q;
    assign diff      = diff_q;
    assign bout      = bout_q;
    assign ovf       = ovf_q;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        borrow_d    = borrow_q;
        a_d         = a_q;
        b_d         = b_q;
        bout_d      = bout_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    a_d      = inp1;
                    b_d      = inp2;
                    borrow_d = 1'b0;
                    idx_d    = '0;
                    state_d  = SUB;
                end
            end
            SUB: begin
                borrow_d = slice_b;
                if (last_chunk) begin
                    bout_d      = slice_b;
                    ovf_d       = (a_q[N-1] != b_q[N-1]) && (slice_d[W-1] != a_q[N-1]);
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            borrow_q    <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            diff_q      <= '0;
            bout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            borrow_q    <= borrow_d;
            a_q         <= a_d;
            b_q         <= b_d;
            diff_q      <= diff_d;
            bout_q      <= bout_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end
endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: directed operand pairs feed a queue of expected
// results; a negedge monitor pops and compares each delivered result.
module tb_serial_subtractor;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] inp1 = '0;
    logic [63:0] inp2 = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] diff;
    logic        bout;
    logic        ovf;

    typedef struct {
        logic [63:0] d;
        logic        bo;
        logic        ov;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    serial_subtractor #(.N(64), .W(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .inp1(inp1), .inp2(inp2),
        .out_valid(out_valid), .out_ready(out_ready),
        .diff(diff), .bout(bout), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: every accepted result is matched against the oldest expectation.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_result actual=%h/%0b/%0b required=none", diff, bout, ovf);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (diff !== e.d || bout !== e.bo || ovf !== e.ov) begin
                    failures++;
                    $display("FAIL result actual=%h/%0b/%0b required=%h/%0b/%0b",
                             diff, bout, ovf, e.d, e.bo, e.ov);
                end else begin
                    $display("result diff=%h bout=%0b ovf=%0b ok", diff, bout, ovf);
                end
            end
        end
    end

    task automatic offer(input logic [63:0] a, input logic [63:0] b);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("in_ready_before_accept", 64'(in_ready), 64'd1);
        inp1 = a;
        inp2 = b;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic do_op(input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] d, input logic bo, input logic ov);
        int n;
        exp_q.push_back('{d, bo, ov});
        offer(a, b);
        chk("in_ready_after_accept", 64'(in_ready), 64'd0);
        wait_out(n);
        chk("latency_edges", 64'(n), 64'd4);
        @(posedge clk); #1;
        chk("out_valid_one_cycle", 64'(out_valid), 64'd0);
        chk("in_ready_return", 64'(in_ready), 64'd1);
    endtask

    initial begin
        int n;
        @(posedge clk); #1;
        chk("in_ready_in_reset", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_diff", diff, 64'd0);
        chk("reset_bout", 64'(bout), 64'd0);
        chk("reset_ovf", 64'(ovf), 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd1);

        do_op(64'd100, 64'd58, 64'd42, 1'b0, 1'b0);
        do_op(64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
        do_op(64'h0000_0001_0000_0000, 64'd1, 64'h0000_0000_FFFF_FFFF, 1'b0, 1'b0);
        do_op(64'h8000_0000_0000_0000, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1);
        do_op(64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
              64'h8000_0000_0000_0000, 1'b1, 1'b1);
        do_op(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321,
              64'h0246_8ACF_1357_9BCF, 1'b0, 1'b0);

        // Back-pressure in DONE while new operands are offered.
        out_ready = 1'b0;
        exp_q.push_back('{64'd999, 1'b0, 1'b0});
        offer(64'd1000, 64'd1);
        wait_out(n);
        chk("stall_latency_edges", 64'(n), 64'd4);
        for (int i = 0; i < 5; i++) begin
            in_valid = (i % 2 == 0);
            inp1 = 64'hDEAD_0000 + 64'(i);
            inp2 = 64'd5;
            @(posedge clk); #1;
            chk("stall_out_valid", 64'(out_valid), 64'd1);
            chk("stall_diff", diff, 64'd999);
            chk("stall_bout", 64'(bout), 64'd0);
            chk("stall_ovf", 64'(ovf), 64'd0);
            chk("stall_in_ready", 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("stall_release_out_valid", 64'(out_valid), 64'd0);
        chk("stall_release_in_ready", 64'(in_ready), 64'd1);
        repeat (6) @(posedge clk);
        #1;
        chk("no_stray_capture", 64'(out_valid), 64'd0);

        // Reset in the middle of an operation (idx == 2).
        offer(64'd5, 64'd3);
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("in_ready_during_rst", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        chk("abort_diff", diff, 64'd0);
        chk("abort_bout", 64'(bout), 64'd0);
        chk("abort_ovf", 64'(ovf), 64'd0);
        chk("abort_in_ready", 64'(in_ready), 64'd1);
        repeat (6) @(posedge clk);
        #1;
        chk("abort_no_output", 64'(out_valid), 64'd0);
        do_op(64'd7, 64'd9, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0);

        repeat (2) @(posedge clk);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
